// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared definitions for the two-cache memory bus: default bus widths,
//   request codes (same values the cache drives), arbiter FSM states and a
//   small helper used when deciding whether a port request can be captured.
package mem_bus_arbiter_pkg;

  localparam int BUS_ADDRWIDTH = 16;
  localparam int BUS_WORDWIDTH = 16;
  localparam int IOSTATEWIDTH  = 2;

  // Request codes on rwFromCacheN; 3 is never legal.
  localparam logic [IOSTATEWIDTH-1:0] RD   = 2'd0;
  localparam logic [IOSTATEWIDTH-1:0] WT   = 2'd1;
  localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'd2;
  localparam logic [IOSTATEWIDTH-1:0] ILL  = 2'd3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arbState_t;

  // True for codes that open a memory access.
  function automatic logic isReq(logic [IOSTATEWIDTH-1:0] rw);
    return (rw == RD) || (rw == WT);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bus between the two cache instances and the shared memory arbiter.
//   Ports:
//     rwFromCacheN / addrFromCacheN / dataFromCacheN : request from cache N
//     readEnToCacheN / writeDoneToCacheN              : 1-cycle completion pulses
//     addrToCacheN / dataToCacheN                     : completed address / read data
//     errOut                                          : sticky illegal-code flag
//   Modports: master = cache side, slave = arbiter side.
interface mem_bus_arbiter_if #(
  parameter int ADDRWIDTH = 16,
  parameter int WORDWIDTH = 16
);

  logic [1:0]           rwFromCache0,   rwFromCache1;
  logic [ADDRWIDTH-1:0] addrFromCache0, addrFromCache1;
  logic [WORDWIDTH-1:0] dataFromCache0, dataFromCache1;

  logic                 readEnToCache0,    readEnToCache1;
  logic                 writeDoneToCache0, writeDoneToCache1;
  logic [ADDRWIDTH-1:0] addrToCache0,      addrToCache1;
  logic [WORDWIDTH-1:0] dataToCache0,      dataToCache1;
  logic                 errOut;

  modport master (
    output rwFromCache0, addrFromCache0, dataFromCache0,
    output rwFromCache1, addrFromCache1, dataFromCache1,
    input  readEnToCache0, writeDoneToCache0, addrToCache0, dataToCache0,
    input  readEnToCache1, writeDoneToCache1, addrToCache1, dataToCache1,
    input  errOut
  );

  modport slave (
    input  rwFromCache0, addrFromCache0, dataFromCache0,
    input  rwFromCache1, addrFromCache1, dataFromCache1,
    output readEnToCache0, writeDoneToCache0, addrToCache0, dataToCache0,
    output readEnToCache1, writeDoneToCache1, addrToCache1, dataToCache1,
    output errOut
  );

endinterface

// File: rtl/mem_bus_arbiter_mem_array.sv
// mem_array
//   Main memory model: single port, synchronous write, asynchronous read.
//   Contents are never reset; a location reads undefined until written.
//   Ports:
//     clk    : clock
//     we     : write enable for this cycle
//     idx    : word index (shared by read and write)
//     wrData : write word
//     rdData : combinational read of mem[idx]
module mem_array #(
  parameter int WORDWIDTH    = 16,
  parameter int MEMADDRWIDTH = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [MEMADDRWIDTH-1:0] idx,
  input  logic [WORDWIDTH-1:0]    wrData,
  output logic [WORDWIDTH-1:0]    rdData
);

  localparam int DEPTH = 1 << MEMADDRWIDTH;

  logic [WORDWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wrData;
  end

  assign rdData = mem[idx];

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shared memory side of the two-cache snooping system. Each cache port owns
//   one request slot; captured requests are served one at a time with
//   round-robin priority against an internal word array with a fixed number
//   of BUSY cycles per access. Completion is a one-cycle readEn / writeDone
//   pulse on the requesting port, with the address (and read data) held in
//   registers until that port's next completion.
//   Ports:
//     clk   : clock, all state on posedge
//     reset : asynchronous, active-low
//     bus   : mem_bus_arbiter_if slave modport (requests in, completions out)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDRWIDTH    = BUS_ADDRWIDTH,
  parameter int WORDWIDTH    = BUS_WORDWIDTH,
  parameter int MEMADDRWIDTH = 8,
  parameter int LATENCY      = 4   // BUSY cycles per access, 1..15
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_bus_arbiter_if.slave     bus
);

  localparam int NPORT = 2;

  // Port inputs gathered into packed arrays so per-port logic can loop.
  logic [NPORT-1:0][1:0]           rwIn;
  logic [NPORT-1:0][ADDRWIDTH-1:0] addrIn;
  logic [NPORT-1:0][WORDWIDTH-1:0] dataIn;

  assign rwIn[0]   = bus.rwFromCache0;
  assign rwIn[1]   = bus.rwFromCache1;
  assign addrIn[0] = bus.addrFromCache0;
  assign addrIn[1] = bus.addrFromCache1;
  assign dataIn[0] = bus.dataFromCache0;
  assign dataIn[1] = bus.dataFromCache1;

  // Request slots
  logic [NPORT-1:0]                pending;
  logic [NPORT-1:0][1:0]           slotRw;
  logic [NPORT-1:0][ADDRWIDTH-1:0] slotAddr;
  logic [NPORT-1:0][WORDWIDTH-1:0] slotData;

  // Arbiter FSM
  arbState_t  state, stateNxt;
  logic [3:0] cnt, cntNxt;
  logic       grant, grantNxt;
  logic       lastGrant, lastGrantNxt;
  logic       access;          // BUSY with cnt==0: the array access edge
  logic [NPORT-1:0] doneClr;   // DONE cycle: slot frees on this edge

  // Completion outputs
  logic [NPORT-1:0]                readEnR, writeDoneR;
  logic [NPORT-1:0][ADDRWIDTH-1:0] addrToR;
  logic [NPORT-1:0][WORDWIDTH-1:0] dataToR;
  logic                            errR;

  // Memory
  logic                    memWe;
  logic [WORDWIDTH-1:0]    rdData;
  logic [MEMADDRWIDTH-1:0] memIdx;

  assign memIdx = slotAddr[grant][MEMADDRWIDTH-1:0];

  // Slot capture. A full slot (including its DONE cycle) ignores the port,
  // so a held request level is only re-captured the cycle after the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      slotRw   <= '0;
      slotAddr <= '0;
      slotData <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (!pending[p] && isReq(rwIn[p])) begin
          pending[p]  <= 1'b1;
          slotRw[p]   <= rwIn[p];
          slotAddr[p] <= addrIn[p];
          slotData[p] <= dataIn[p];
        end else if (doneClr[p]) begin
          pending[p] <= 1'b0;
        end
      end
    end
  end

  // Illegal code is only noticed while the slot would have accepted it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      errR <= 1'b0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (!pending[p] && (rwIn[p] == ILL)) errR <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      cnt       <= '0;
      grant     <= 1'b0;
      lastGrant <= 1'b1;   // port 0 wins the first tie
    end else begin
      state     <= stateNxt;
      cnt       <= cntNxt;
      grant     <= grantNxt;
      lastGrant <= lastGrantNxt;
    end
  end

  always_comb begin
    stateNxt     = state;
    cntNxt       = cnt;
    grantNxt     = grant;
    lastGrantNxt = lastGrant;
    access       = 1'b0;
    memWe        = 1'b0;
    doneClr      = '0;
    case (state)
      ARB_IDLE: begin
        if (pending != '0) begin
          // Tie goes to the port that was not served last.
          if (pending == 2'b11) grantNxt = ~lastGrant;
          else                  grantNxt = pending[1];
          lastGrantNxt = grantNxt;
          cntNxt       = 4'(LATENCY - 1);
          stateNxt     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (cnt != 4'd0) begin
          cntNxt = cnt - 4'd1;
        end else begin
          access   = 1'b1;
          memWe    = (slotRw[grant] == WT);
          stateNxt = ARB_DONE;
        end
      end
      ARB_DONE: begin
        doneClr[grant] = 1'b1;
        stateNxt       = ARB_IDLE;
      end
      default: stateNxt = ARB_IDLE;
    endcase
  end

  // Completion registers load on the access edge so the pulse and the
  // address/data line up exactly with the DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readEnR    <= '0;
      writeDoneR <= '0;
      addrToR    <= '0;
      dataToR    <= '0;
    end else begin
      readEnR    <= '0;
      writeDoneR <= '0;
      if (access) begin
        addrToR[grant] <= slotAddr[grant];
        if (slotRw[grant] == RD) begin
          readEnR[grant] <= 1'b1;
          dataToR[grant] <= rdData;
        end else begin
          writeDoneR[grant] <= 1'b1;
        end
      end
    end
  end

  mem_array #(
    .WORDWIDTH    (WORDWIDTH),
    .MEMADDRWIDTH (MEMADDRWIDTH)
  ) uMem (
    .clk    (clk),
    .we     (memWe),
    .idx    (memIdx),
    .wrData (slotData[grant]),
    .rdData (rdData)
  );

  assign bus.readEnToCache0    = readEnR[0];
  assign bus.readEnToCache1    = readEnR[1];
  assign bus.writeDoneToCache0 = writeDoneR[0];
  assign bus.writeDoneToCache1 = writeDoneR[1];
  assign bus.addrToCache0      = addrToR[0];
  assign bus.addrToCache1      = addrToR[1];
  assign bus.dataToCache0      = dataToR[0];
  assign bus.dataToCache1      = dataToR[1];
  assign bus.errOut            = errR;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed scenarios followed by randomized traffic, all checked every cycle
//   against a transaction-level model: each served request occupies the
//   memory for LATENCY+1 cycles after its grant, with round-robin choice when
//   both ports are waiting.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDRWIDTH(16), .WORDWIDTH(16)) bus ();

  mem_bus_arbiter #(
    .ADDRWIDTH(16), .WORDWIDTH(16), .MEMADDRWIDTH(8), .LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nVec = 0;
  int nErr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          cyc;
  bit          mPend [2];
  logic [1:0]  mRw   [2];
  logic [15:0] mAddr [2];
  logic [15:0] mData [2];
  bit          mBusy;
  int          mDoneCyc;
  int          mG;
  int          mLast;
  bit          mErr;
  logic [15:0] mem [256];
  bit          memKnown [256];
  logic [15:0] accData;
  bit          accKnown;
  bit          expRd [2];
  bit          expWd [2];
  logic [15:0] expAddr [2];
  logic [15:0] expData [2];
  bit          expKnown [2];

  function automatic void modelReset();
    for (int p = 0; p < 2; p++) begin
      mPend[p] = 0; expRd[p] = 0; expWd[p] = 0;
      expAddr[p] = '0; expData[p] = '0; expKnown[p] = 1;
    end
    mBusy = 0; mLast = 1; mErr = 0;
  endfunction

  task automatic drive(input logic [1:0] r0, input logic [15:0] a0, input logic [15:0] d0,
                       input logic [1:0] r1, input logic [15:0] a1, input logic [15:0] d1);
    bus.rwFromCache0 = r0; bus.addrFromCache0 = a0; bus.dataFromCache0 = d0;
    bus.rwFromCache1 = r1; bus.addrFromCache1 = a1; bus.dataFromCache1 = d1;
  endtask

  task automatic checkOutputs(input bit expErr);
    chk("readEn0",    bus.readEnToCache0,    expRd[0]);
    chk("writeDone0", bus.writeDoneToCache0, expWd[0]);
    chk("addrTo0",    bus.addrToCache0,      expAddr[0]);
    if (expKnown[0]) chk("dataTo0", bus.dataToCache0, expData[0]);
    chk("readEn1",    bus.readEnToCache1,    expRd[1]);
    chk("writeDone1", bus.writeDoneToCache1, expWd[1]);
    chk("addrTo1",    bus.addrToCache1,      expAddr[1]);
    if (expKnown[1]) chk("dataTo1", bus.dataToCache1, expData[1]);
    chk("errOut",     bus.errOut,            expErr);
  endtask

  // One clock cycle: inputs applied just after posedge, outputs compared at
  // negedge, model advanced to the next edge.
  task automatic step(input logic [1:0] r0, input logic [15:0] a0, input logic [15:0] d0,
                      input logic [1:0] r1, input logic [15:0] a1, input logic [15:0] d1);
    logic [1:0]  rIn [2];
    logic [15:0] aIn [2];
    logic [15:0] dIn [2];
    bit          oldPend [2];
    bit          completing;
    int          g;
    rIn[0] = r0; aIn[0] = a0; dIn[0] = d0;
    rIn[1] = r1; aIn[1] = a1; dIn[1] = d1;
    drive(r0, a0, d0, r1, a1, d1);

    completing = mBusy && (cyc == mDoneCyc);
    expRd[0] = 0; expRd[1] = 0; expWd[0] = 0; expWd[1] = 0;
    if (completing) begin
      expAddr[mG] = mAddr[mG];
      if (mRw[mG] == RD) begin
        expRd[mG] = 1; expData[mG] = accData; expKnown[mG] = accKnown;
      end else begin
        expWd[mG] = 1;
      end
    end

    @(negedge clk);
    checkOutputs(mErr);

    oldPend = mPend;
    if (mBusy && (cyc == mDoneCyc - 1)) begin
      if (mRw[mG] == WT) begin
        mem[mAddr[mG][7:0]] = mData[mG];
        memKnown[mAddr[mG][7:0]] = 1;
      end else begin
        accData  = mem[mAddr[mG][7:0]];
        accKnown = memKnown[mAddr[mG][7:0]];
      end
    end
    if (!mBusy && (oldPend[0] || oldPend[1])) begin
      if (oldPend[0] && oldPend[1]) g = 1 - mLast;
      else                          g = oldPend[1] ? 1 : 0;
      mG = g; mLast = g; mBusy = 1; mDoneCyc = cyc + LAT + 1;
    end
    if (completing) begin
      mPend[mG] = 0; mBusy = 0;
    end
    for (int p = 0; p < 2; p++) begin
      if (!oldPend[p]) begin
        if (rIn[p] == RD || rIn[p] == WT) begin
          mPend[p] = 1; mRw[p] = rIn[p]; mAddr[p] = aIn[p]; mData[p] = dIn[p];
        end else if (rIn[p] == ILL) begin
          mErr = 1;
        end
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(IDEL, 16'h0, 16'h0, IDEL, 16'h0, 16'h0);
  endtask

  // Asynchronous reset asserted mid-cycle, checked while held, released at negedge.
  task automatic doReset();
    drive(IDEL, 16'h0, 16'h0, IDEL, 16'h0, 16'h0);
    #2 reset = 1'b0;
    modelReset();
    #1;
    checkOutputs(1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [1:0]  rr [2];
  logic [15:0] ra [2];
  logic [15:0] rd [2];

  initial begin
    for (int i = 0; i < 256; i++) memKnown[i] = 0;
    accData = '0; accKnown = 0; cyc = 0; mG = 0; mDoneCyc = 0;
    modelReset();
    drive(IDEL, 16'h0, 16'h0, IDEL, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    doReset();

    // Single write, then read back on port 0
    step(WT, 16'h0012, 16'hBEEF, IDEL, 16'h0, 16'h0);
    idle(8);
    step(RD, 16'h0012, 16'h0, IDEL, 16'h0, 16'h0);
    idle(8);

    // Simultaneous reads after reset, twice
    doReset();
    step(RD, 16'h0012, 16'h0, RD, 16'h0012, 16'h0);
    idle(14);
    step(RD, 16'h0012, 16'h0, RD, 16'h0012, 16'h0);
    idle(14);

    // Make port 0 the last grant, then write(p1)/read(p0) collide
    step(RD, 16'h0012, 16'h0, IDEL, 16'h0, 16'h0);
    idle(8);
    step(RD, 16'h0040, 16'h0, WT, 16'h0040, 16'h1234);
    idle(14);

    // Held read level for 10 cycles
    for (int i = 0; i < 10; i++) step(RD, 16'h0005, 16'h0, IDEL, 16'h0, 16'h0);
    idle(10);

    // Write lost to reset during BUSY
    step(WT, 16'h0007, 16'h5555, IDEL, 16'h0, 16'h0);
    idle(8);
    step(WT, 16'h0007, 16'hAAAA, IDEL, 16'h0, 16'h0);
    idle(2);
    doReset();
    step(RD, 16'h0007, 16'h0, IDEL, 16'h0, 16'h0);
    idle(8);

    // Illegal code on port 1
    step(IDEL, 16'h0, 16'h0, ILL, 16'h0033, 16'h0);
    idle(8);
    doReset();
    idle(2);

    // Seed a small address window so random reads have known data
    for (int i = 0; i < 8; i++) begin
      step(WT, 16'(i), 16'($urandom()), IDEL, 16'h0, 16'h0);
      idle(7);
    end

    // Randomized traffic
    for (int p = 0; p < 2; p++) begin rr[p] = IDEL; ra[p] = '0; rd[p] = '0; end
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        doReset();
      end else begin
        for (int p = 0; p < 2; p++) begin
          if ($urandom_range(0, 99) >= 30) begin
            int r;
            r = $urandom_range(0, 199);
            if      (r < 30) rr[p] = RD;
            else if (r < 60) rr[p] = WT;
            else if (r < 61) rr[p] = ILL;
            else             rr[p] = IDEL;
            ra[p] = {8'($urandom()), 5'd0, 3'($urandom_range(0, 7))};
            rd[p] = 16'($urandom());
          end
        end
        step(rr[0], ra[0], rd[0], rr[1], ra[1], rd[1]);
      end
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
